// File: rtl/instr_sequencer_if.sv
// Host/CPU-facing bus of instr_sequencer: program load port, run control
// and the registered instruction issue outputs.
interface instr_sequencer_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 4
);
  logic                   load_valid;
  logic                   load_ready;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_clear;
  logic                   start;
  logic                   halt;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   issue;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   done;

  modport master (
    output load_valid, load_data, load_clear, start, halt,
    input  load_ready, instruction, issue, pc, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_clear, start, halt,
    output load_ready, instruction, issue, pc, busy, done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program buffer plus issue FSM feeding simple_cpu one instruction every ISSUE_GAP cycles.
// Optional SEQ_LOOP_EN: the program repeats from PC 0 until halt or reset instead of finishing.
module instr_sequencer #(
  parameter int                     INSTR_WIDTH = 20,
  parameter int                     PC_BITS     = 4,
  parameter int                     ISSUE_GAP   = 3,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = 20'h00000
) (
  input  logic             clk,
  input  logic             rst,
  instr_sequencer_if.slave bus
);
  localparam int                   DEPTH    = 1 << PC_BITS;
  localparam int                   GAP_W    = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(ISSUE_GAP - 1);
  localparam logic [GAP_W-1:0]     GAP_ZERO = '0;
  localparam logic [PC_BITS:0]     FULL_LEN = (PC_BITS + 1)'(DEPTH);
  localparam logic [PC_BITS:0]     LEN_ZERO = '0;
  localparam logic [PC_BITS-1:0]   PC_ZERO  = '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [INSTR_WIDTH-1:0] mem_r [DEPTH];
  state_t                 state_r;
  logic [PC_BITS:0]       prog_len_r;
  logic [PC_BITS-1:0]     pc_r;
  logic [GAP_W-1:0]       gap_r;
  logic [INSTR_WIDTH-1:0] instruction_r;
  logic                   issue_r;
  logic                   busy_r;
  logic                   done_r;

  logic                   load_ready_s;
  logic                   handshake_s;
  logic                   last_s;
  logic [PC_BITS-1:0]     pc_next_s;
  logic                   start_ok_s;

  // Load acceptance and run-step decode.
  always_comb begin
    load_ready_s = 1'b0;
    if ((state_r == ST_IDLE) && (prog_len_r != FULL_LEN)) begin
      load_ready_s = 1'b1;
    end else begin
      load_ready_s = 1'b0;
    end
    handshake_s = bus.load_valid & load_ready_s;
    last_s      = ({1'b0, pc_r} == (prog_len_r - (PC_BITS + 1)'(1)));
    pc_next_s   = pc_r + PC_BITS'(1);
    // A same-cycle clear would leave the run with an empty program, so it also blocks start.
    start_ok_s  = bus.start & ~bus.halt & ~handshake_s & ~bus.load_clear &
                  (prog_len_r != LEN_ZERO);
  end

  // Program storage; deliberately not reset, prog_len gates what is reachable.
  always_ff @(posedge clk) begin
    if (rst && handshake_s && !bus.load_clear) begin
      mem_r[prog_len_r[PC_BITS-1:0]] <= bus.load_data;
    end
  end

  // Sequencer FSM with registered issue outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      prog_len_r    <= LEN_ZERO;
      pc_r          <= PC_ZERO;
      gap_r         <= GAP_ZERO;
      instruction_r <= NOP_WORD;
      issue_r       <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      issue_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.load_clear) begin
            prog_len_r <= LEN_ZERO;
          end else if (handshake_s) begin
            prog_len_r <= prog_len_r + (PC_BITS + 1)'(1);
          end
          if (start_ok_s) begin
            state_r       <= ST_RUN;
            busy_r        <= 1'b1;
            pc_r          <= PC_ZERO;
            gap_r         <= GAP_ZERO;
            instruction_r <= mem_r[PC_ZERO];
            issue_r       <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.halt) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            pc_r          <= PC_ZERO;
            gap_r         <= GAP_ZERO;
            instruction_r <= NOP_WORD;
          end else if (gap_r == GAP_LAST) begin
            gap_r <= GAP_ZERO;
            if (last_s) begin
`ifdef SEQ_LOOP_EN
              pc_r          <= PC_ZERO;
              instruction_r <= mem_r[PC_ZERO];
              issue_r       <= 1'b1;
`else
              state_r       <= ST_IDLE;
              busy_r        <= 1'b0;
              pc_r          <= PC_ZERO;
              instruction_r <= NOP_WORD;
              done_r        <= 1'b1;
`endif
            end else begin
              pc_r          <= pc_next_s;
              instruction_r <= mem_r[pc_next_s];
              issue_r       <= 1'b1;
            end
          end else begin
            gap_r <= gap_r + GAP_W'(1);
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          busy_r        <= 1'b0;
          pc_r          <= PC_ZERO;
          gap_r         <= GAP_ZERO;
          instruction_r <= NOP_WORD;
        end
      endcase
    end
  end

  assign bus.load_ready  = load_ready_s;
  assign bus.instruction = instruction_r;
  assign bus.issue       = issue_r;
  assign bus.pc          = pc_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer against a program-queue model.
module tb_instr_sequencer;
  localparam int IW    = 20;
  localparam int PB    = 4;
  localparam int DEPTH = 16;
`ifdef SEQ_LOOP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 3;
`endif
  localparam logic [IW-1:0] NOP = 20'h00000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if #(.INSTR_WIDTH(IW), .PC_BITS(PB)) bus ();

  instr_sequencer #(.INSTR_WIDTH(IW), .PC_BITS(PB), .ISSUE_GAP(GAP), .NOP_WORD(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [IW-1:0] prog[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_clear = 1'b0;
    bus.start      = 1'b0;
    bus.halt       = 1'b0;
  endtask

  task automatic load_word(input logic [IW-1:0] w);
    logic exp_ready;
    exp_ready      = (prog.size() != DEPTH);
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    #1;
    tests_run++;
    if (bus.load_ready !== exp_ready) begin
      tests_failed++;
      $display("FAIL load_ready: got %b expected %b (model len %0d)", bus.load_ready, exp_ready, prog.size());
    end
    step();
    if (exp_ready) prog.push_back(w);
    bus.load_valid = 1'b0;
  endtask

  task automatic clear_prog();
    bus.load_clear = 1'b1;
    step();
    bus.load_clear = 1'b0;
    prog.delete();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    step();
    step();
    tests_run++;
    if ({bus.instruction, bus.pc, bus.issue, bus.busy, bus.done, bus.load_ready} !== {NOP, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got instr=%h pc=%0d issue=%b busy=%b done=%b ready=%b expected %h/0/0/0/0/1",
               bus.instruction, bus.pc, bus.issue, bus.busy, bus.done, bus.load_ready, NOP);
    end
    rst = 1'b1;
    step();
    prog.delete();
  endtask

  // Starts the current model program and checks every cycle of the run.
  task automatic test_run_program(input string name);
    int n;
    int cycles;
    int k;
    int issues;
    int exp_issues;
    logic [IW-1:0] exp_instr;
    logic [PB-1:0] exp_pc;
    logic exp_issue;
    n          = prog.size();
    issues     = 0;
    exp_issues = 0;
`ifdef SEQ_LOOP_EN
    cycles = (2 * n * GAP > 20) ? 2 * n * GAP : 20;
`else
    cycles = n * GAP;
`endif
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      k         = (c / GAP) % n;
      exp_instr = prog[k];
      exp_pc    = k[PB-1:0];
      exp_issue = ((c % GAP) == 0);
      if (exp_issue) exp_issues++;
      if (bus.issue === 1'b1) issues++;
      tests_run++;
      if ({bus.instruction, bus.pc, bus.issue, bus.busy, bus.done} !== {exp_instr, exp_pc, exp_issue, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got instr=%h pc=%0d issue=%b busy=%b done=%b expected %h/%0d/%b/1/0",
                 name, c, bus.instruction, bus.pc, bus.issue, bus.busy, bus.done, exp_instr, exp_pc, exp_issue);
      end
      step();
    end
    tests_run++;
    if (issues != exp_issues) begin
      tests_failed++;
      $display("FAIL %s issue_count: got %0d expected %0d", name, issues, exp_issues);
    end
`ifdef SEQ_LOOP_EN
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    tests_run++;
    if ({bus.instruction, bus.pc, bus.issue, bus.busy, bus.done} !== {NOP, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s loop_halt: got instr=%h pc=%0d issue=%b busy=%b done=%b expected %h/0/0/0/0",
               name, bus.instruction, bus.pc, bus.issue, bus.busy, bus.done, NOP);
    end
`else
    tests_run++;
    if ({bus.instruction, bus.pc, bus.issue, bus.busy, bus.done} !== {NOP, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL %s finish: got instr=%h pc=%0d issue=%b busy=%b done=%b expected %h/0/0/0/1",
               name, bus.instruction, bus.pc, bus.issue, bus.busy, bus.done, NOP);
    end
    step();
    tests_run++;
    if ({bus.done, bus.busy, bus.load_ready} !== {1'b0, 1'b0, (prog.size() != DEPTH)}) begin
      tests_failed++;
      $display("FAIL %s after_done: got done=%b busy=%b ready=%b expected 0/0/%b",
               name, bus.done, bus.busy, bus.load_ready, (prog.size() != DEPTH));
    end
`endif
  endtask

  task automatic test_directed();
    clear_prog();
    load_word(20'h10001);
    load_word(20'h20002);
    load_word(20'h30003);
    test_run_program("directed3");
    test_run_program("directed3_rerun");
  endtask

  task automatic test_random_runs();
    int n;
    for (int r = 0; r < 6; r++) begin
      clear_prog();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        load_word(IW'($urandom));
        if ($urandom_range(0, 3) == 0) step();
      end
      test_run_program("random_run");
    end
  endtask

  task automatic test_full();
    clear_prog();
    for (int i = 0; i < DEPTH; i++) load_word(IW'($urandom));
    for (int i = 0; i < 3; i++) load_word(20'hFFFFF);
    test_run_program("full16");
  endtask

  task automatic test_start_ignored();
    logic [IW-1:0] w;
    clear_prog();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    tests_run++;
    if ({bus.busy, bus.issue} !== 2'b00) begin
      tests_failed++;
      $display("FAIL start_empty: got busy=%b issue=%b expected 0/0", bus.busy, bus.issue);
    end
    w = IW'($urandom);
    bus.start = 1'b1;
    load_word(w);
    bus.start = 1'b0;
    tests_run++;
    if ({bus.busy, bus.issue} !== 2'b00) begin
      tests_failed++;
      $display("FAIL start_with_load: got busy=%b issue=%b expected 0/0", bus.busy, bus.issue);
    end
    // Clear wins over a same-cycle load, so the following start sees an empty program.
    bus.load_clear = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = IW'($urandom);
    step();
    drive_idle();
    prog.delete();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    tests_run++;
    if ({bus.busy, bus.issue} !== 2'b00) begin
      tests_failed++;
      $display("FAIL clear_priority: got busy=%b issue=%b expected 0/0", bus.busy, bus.issue);
    end
  endtask

  task automatic test_halt();
    int hc;
    clear_prog();
    for (int i = 0; i < 4; i++) load_word(IW'($urandom));
    hc = GAP + ((GAP > 1) ? 1 : 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < hc; c++) step();
    tests_run++;
    if (bus.instruction !== prog[hc / GAP]) begin
      tests_failed++;
      $display("FAIL halt_pre: got instr=%h expected %h", bus.instruction, prog[hc / GAP]);
    end
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    tests_run++;
    if ({bus.instruction, bus.pc, bus.issue, bus.busy, bus.done} !== {NOP, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL halt_stop: got instr=%h pc=%0d issue=%b busy=%b done=%b expected %h/0/0/0/0",
               bus.instruction, bus.pc, bus.issue, bus.busy, bus.done, NOP);
    end
    for (int c = 0; c < 4 * GAP; c++) begin
      tests_run++;
      if ({bus.done, bus.busy} !== 2'b00) begin
        tests_failed++;
        $display("FAIL halt_quiet cycle %0d: got done=%b busy=%b expected 0/0", c, bus.done, bus.busy);
      end
      step();
    end
    test_run_program("halt_rerun");
  endtask

  task automatic test_reset_mid_run();
    clear_prog();
    for (int i = 0; i < 3; i++) load_word(IW'($urandom));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    prog.delete();
    tests_run++;
    if ({bus.instruction, bus.pc, bus.issue, bus.busy, bus.done, bus.load_ready} !== {NOP, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_mid_run: got instr=%h pc=%0d issue=%b busy=%b done=%b ready=%b expected %h/0/0/0/0/1",
               bus.instruction, bus.pc, bus.issue, bus.busy, bus.done, bus.load_ready, NOP);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    tests_run++;
    if ({bus.busy, bus.issue} !== 2'b00) begin
      tests_failed++;
      $display("FAIL start_after_reset: got busy=%b issue=%b expected 0/0", bus.busy, bus.issue);
    end
  endtask

  task automatic test_loop_two_words();
    clear_prog();
    load_word(IW'($urandom));
    load_word(IW'($urandom));
    test_run_program("two_word");
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_directed();
    test_random_runs();
    test_full();
    test_start_ignored();
    test_halt();
    test_reset_mid_run();
    test_loop_two_words();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
